serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Bit-serial W-bit subtractor: computes diff = a - b one bit per clock, LSB first, through a single full-subtractor cell and a borrow flip-flop.
- Serves as the sequential counterpart to the combinational half-adder labs: the inverse operation, done serially.
- Sits between board switches (operands) and LEDs (result, borrow, status) in the lab top levels.

Parameters:
- W, 4, operand/result width in bits; legal range 1..16.
- CW, $clog2(W+1), bit-counter width; derived, not overridden.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  level-sampled request; acted on only in IDLE or DONE.
- a  input  W  minuend; sampled on the accepting edge only.
- b  input  W  subtrahend; sampled on the accepting edge only.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse when the result becomes valid.
- diff  output  W  result (a - b) mod 2^W; held until the next accepted start.
- borrow_out  output  1  final borrow, 1 iff a < b unsigned; held with diff.

Behaviour:
- Reset (asynchronous, rst=1):
  - FSM goes to IDLE.
  - busy=0, done=0, diff=0, borrow_out=0.
  - Internal shift registers, borrow flip-flop and counter all cleared.
  - Applies immediately, including mid-RUN; the partial result is discarded and no done is issued.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at edge k: latch a into sa and b into sb, borrow_ff=0, cnt=0, diff cleared to 0.
  - Go to RUN.
- RUN, one bit per cycle:
  - d = sa[0] ^ sb[0] ^ borrow_ff.
  - bnext = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & borrow_ff).
  - sa and sb shift right by one.
  - The result register shifts right with d entering at bit W-1.
  - borrow_ff <= bnext; cnt <= cnt + 1.
  - When cnt == W-1 on the current edge: go to DONE, and load borrow_out with bnext.
- Timing:
  - busy=1 exactly in cycles k+1 .. k+W (W cycles).
  - done=1 exactly in cycle k+W+1.
  - diff and borrow_out are valid from cycle k+W+1 onward.
- DONE:
  - done=1 for this single cycle.
  - start=1 in this cycle is accepted, same actions as in IDLE; done still pulses in this cycle, and the next result begins.
  - Otherwise go to IDLE.
- start while busy (RUN) is ignored; there is no queueing.
- a and b changing during RUN have no effect.
- diff and borrow_out change only at reset, at the accepting edge (cleared), and during RUN shifting. A bench samples them only when done=1 or in IDLE afterwards.
- W=1 case: RUN lasts one cycle; done comes at k+2.
- All arithmetic is unsigned modulo 2^W; there is no overflow flag.

Test Plan:
- W=4, a=9, b=3, start pulse at edge k -> busy high for 4 cycles; done at k+5; diff=6, borrow_out=0.
- W=4, a=3, b=9 -> diff=4'b1010 (10), borrow_out=1; values held in IDLE for 10+ cycles afterwards.
- W=4, edge pairs a=b=15 and a=b=0 -> diff=0, borrow_out=0 in both runs; a=0, b=1 -> diff=15, borrow_out=1.
- W=4, a=9, b=3 accepted, start re-asserted with a=1, b=2 in cycle k+2 -> ignored; result diff=6; next accepted start (in DONE) yields diff=15, borrow_out=1, back-to-back with no IDLE cycle.
- W=4, rst asserted mid-RUN (cycle k+2) asynchronously between edges -> busy, done, diff and borrow_out drop to 0 immediately; no done follows; a fresh start with a=5, b=5 gives diff=0.
- W=1 variant, all four (a,b) combos -> diff/borrow_out = 0/0, 1/0, 1/1, 0/0 for (0,0), (1,0), (0,1), (1,1); done at k+2.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial W-bit subtractor (diff = a - b, LSB first) through one full-subtractor cell and a borrow flop.
// Result valid W+1 cycles after the accepting edge; start is ignored while busy, with no queueing.
module serial_subtractor #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] diff,
  output logic         borrow_out
);

  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [W-1:0]  sa_q, sa_d;
  logic [W-1:0]  sb_q, sb_d;
  logic [W-1:0]  diff_q, diff_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          borrow_q, borrow_d;
  logic          borrow_out_q, borrow_out_d;
  logic          dbit;
  logic          bnext;

  always_comb begin
    dbit  = sa_q[0] ^ sb_q[0] ^ borrow_q;
    bnext = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & borrow_q);

    state_d      = state_q;
    sa_d         = sa_q;
    sb_d         = sb_q;
    diff_d       = diff_q;
    cnt_d        = cnt_q;
    borrow_d     = borrow_q;
    borrow_out_d = borrow_out_q;

    case (state_q)
      IDLE, DONE: begin
        // DONE accepts a new start so results can run back-to-back.
        if (start) begin
          sa_d         = a;
          sb_d         = b;
          borrow_d     = 1'b0;
          cnt_d        = '0;
          diff_d       = '0;
          borrow_out_d = 1'b0;
          state_d      = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        sa_d          = sa_q >> 1;
        sb_d          = sb_q >> 1;
        diff_d        = diff_q >> 1;
        diff_d[W-1]   = dbit;
        borrow_d      = bnext;
        cnt_d         = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          borrow_out_d = bnext;
          state_d      = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      sa_q         <= '0;
      sb_q         <= '0;
      diff_q       <= '0;
      cnt_q        <= '0;
      borrow_q     <= 1'b0;
      borrow_out_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sa_q         <= sa_d;
      sb_q         <= sb_d;
      diff_q       <= diff_d;
      cnt_q        <= cnt_d;
      borrow_q     <= borrow_d;
      borrow_out_q <= borrow_out_d;
    end
  end

  assign busy       = (state_q == RUN);
  assign done       = (state_q == DONE);
  assign diff       = diff_q;
  assign borrow_out = borrow_out_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: W=4 and W=1 instances, table vectors plus multi-cycle sequences.
module tb_serial_subtractor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start4;
  logic [3:0] a4, b4;
  logic       busy4, done4, bo4;
  logic [3:0] diff4;

  logic       start1;
  logic [0:0] a1, b1;
  logic       busy1, done1, bo1;
  logic [0:0] diff1;

  int n_vec = 0;
  int n_bad = 0;

  serial_subtractor #(.W(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .diff(diff4), .borrow_out(bo4)
  );

  serial_subtractor #(.W(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .diff(diff1), .borrow_out(bo1)
  );

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] diff;
    logic       bo;
  } vec4_t;

  typedef struct {
    logic a;
    logic b;
    logic diff;
    logic bo;
  } vec1_t;

  vec4_t vt4[8];
  vec1_t vt1[4];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Start at edge k; busy in cycles k+1..k+4, done in k+5. Operands scrambled during RUN.
  task automatic run4(input logic [3:0] a, input logic [3:0] b,
                      input logic [3:0] ed, input logic ebo, input string nm);
    @(negedge clk);
    start4 = 1'b1; a4 = a; b4 = b;
    @(posedge clk);
    #1 start4 = 1'b0; a4 = ~a; b4 = ~b;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk({nm, ".busy"}, 16'(busy4), 16'd1);
      chk({nm, ".done_early"}, 16'(done4), 16'd0);
    end
    @(negedge clk);
    chk({nm, ".done"}, 16'(done4), 16'd1);
    chk({nm, ".busy_end"}, 16'(busy4), 16'd0);
    chk({nm, ".diff"}, 16'(diff4), 16'(ed));
    chk({nm, ".borrow"}, 16'(bo4), 16'(ebo));
  endtask

  task automatic run1(input logic a, input logic b, input logic ed, input logic ebo, input string nm);
    @(negedge clk);
    start1 = 1'b1; a1 = a; b1 = b;
    @(posedge clk);
    #1 start1 = 1'b0;
    @(negedge clk);
    chk({nm, ".busy"}, 16'(busy1), 16'd1);
    chk({nm, ".done_early"}, 16'(done1), 16'd0);
    @(negedge clk);
    chk({nm, ".done"}, 16'(done1), 16'd1);
    chk({nm, ".diff"}, 16'(diff1), 16'(ed));
    chk({nm, ".borrow"}, 16'(bo1), 16'(ebo));
  endtask

  initial begin
    vt4[0] = '{a: 4'd9,  b: 4'd3,  diff: 4'd6,  bo: 1'b0};
    vt4[1] = '{a: 4'd3,  b: 4'd9,  diff: 4'd10, bo: 1'b1};
    vt4[2] = '{a: 4'd15, b: 4'd15, diff: 4'd0,  bo: 1'b0};
    vt4[3] = '{a: 4'd0,  b: 4'd0,  diff: 4'd0,  bo: 1'b0};
    vt4[4] = '{a: 4'd0,  b: 4'd1,  diff: 4'd15, bo: 1'b1};
    vt4[5] = '{a: 4'd8,  b: 4'd1,  diff: 4'd7,  bo: 1'b0};
    vt4[6] = '{a: 4'd0,  b: 4'd15, diff: 4'd1,  bo: 1'b1};
    vt4[7] = '{a: 4'd12, b: 4'd5,  diff: 4'd7,  bo: 1'b0};

    vt1[0] = '{a: 1'b0, b: 1'b0, diff: 1'b0, bo: 1'b0};
    vt1[1] = '{a: 1'b1, b: 1'b0, diff: 1'b1, bo: 1'b0};
    vt1[2] = '{a: 1'b0, b: 1'b1, diff: 1'b1, bo: 1'b1};
    vt1[3] = '{a: 1'b1, b: 1'b1, diff: 1'b0, bo: 1'b0};

    rst = 1'b1;
    start4 = 1'b0; a4 = '0; b4 = '0;
    start1 = 1'b0; a1 = '0; b1 = '0;
    #12;
    chk("rst.busy4", 16'(busy4), 16'd0);
    chk("rst.done4", 16'(done4), 16'd0);
    chk("rst.diff4", 16'(diff4), 16'd0);
    chk("rst.bo4",   16'(bo4),   16'd0);
    chk("rst.busy1", 16'(busy1), 16'd0);
    chk("rst.done1", 16'(done1), 16'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++)
      run4(vt4[i].a, vt4[i].b, vt4[i].diff, vt4[i].bo, $sformatf("w4v%0d", i));

    // Result held in IDLE after completion.
    run4(4'd3, 4'd9, 4'd10, 1'b1, "hold");
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("hold.diff", 16'(diff4), 16'd10);
      chk("hold.bo",   16'(bo4),   16'd1);
      chk("hold.done", 16'(done4), 16'd0);
      chk("hold.busy", 16'(busy4), 16'd0);
    end

    // Start during RUN ignored; held start accepted in DONE, back-to-back.
    @(negedge clk);
    start4 = 1'b1; a4 = 4'd9; b4 = 4'd3;
    @(posedge clk);
    #1 start4 = 1'b0;
    @(negedge clk);
    chk("b2b.busy1", 16'(busy4), 16'd1);
    @(posedge clk);
    #1 start4 = 1'b1; a4 = 4'd1; b4 = 4'd2;
    for (int i = 2; i <= 4; i++) begin
      @(negedge clk);
      chk("b2b.busy_run1", 16'(busy4), 16'd1);
      chk("b2b.done_run1", 16'(done4), 16'd0);
    end
    @(negedge clk);
    chk("b2b.done1", 16'(done4), 16'd1);
    chk("b2b.diff1", 16'(diff4), 16'd6);
    chk("b2b.bo1",   16'(bo4),   16'd0);
    @(posedge clk);
    #1 start4 = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk("b2b.busy_run2", 16'(busy4), 16'd1);
      chk("b2b.done_run2", 16'(done4), 16'd0);
    end
    @(negedge clk);
    chk("b2b.done2", 16'(done4), 16'd1);
    chk("b2b.diff2", 16'(diff4), 16'd15);
    chk("b2b.bo2",   16'(bo4),   16'd1);

    // Asynchronous reset mid-RUN, after two bits have shifted in.
    @(negedge clk);
    start4 = 1'b1; a4 = 4'd9; b4 = 4'd3;
    @(posedge clk);
    #1 start4 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("mrst.busy", 16'(busy4), 16'd0);
    chk("mrst.done", 16'(done4), 16'd0);
    chk("mrst.diff", 16'(diff4), 16'd0);
    chk("mrst.bo",   16'(bo4),   16'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("mrst.no_done", 16'(done4), 16'd0);
      chk("mrst.idle",    16'(busy4), 16'd0);
    end
    run4(4'd5, 4'd5, 4'd0, 1'b0, "post_rst");

    for (int i = 0; i < 4; i++)
      run1(vt1[i].a, vt1[i].b, vt1[i].diff, vt1[i].bo, $sformatf("w1v%0d", i));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
